// File: rtl/io_output_buffer_if.sv
// Byte-serializer bus: core word capture on one side, valid/ready byte sink on the other.
// The master modport is the environment (core + sink); the slave modport is the buffer.
interface io_output_buffer_if #(
    parameter int WIDTH    = 36,
    parameter int PTRWIDTH = 4
) ();
    logic                wordValid;
    logic [WIDTH-1:0]    wordIn;
    logic                byteReady;
    logic                byteValid;
    logic [7:0]          byteOut;
    logic                lastByte;
    logic                full;
    logic                empty;
    logic                overflow;
    logic [PTRWIDTH:0]   count;

    modport master (
        output wordValid, wordIn, byteReady,
        input  byteValid, byteOut, lastByte, full, empty, overflow, count
    );

    modport slave (
        input  wordValid, wordIn, byteReady,
        output byteValid, byteOut, lastByte, full, empty, overflow, count
    );
endinterface

// File: rtl/io_output_buffer.sv
// Captures flagged core result words into a FIFO and streams each one out
// little-endian, one byte per valid/ready handshake. Full-FIFO words are dropped.
module io_output_buffer #(
    parameter int WIDTH    = 36,
    parameter int DEPTH    = 16,
    parameter int PTRWIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    io_output_buffer_if.slave  bus
);
    localparam int BYTES = (WIDTH + 7) / 8;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SHW   = 8 * BYTES;
    localparam int CNTW  = PTRWIDTH + 1;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(BYTES - 1);
    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [0:0]          state_q, state_d;
    logic [SHW-1:0]      shift_q, shift_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                full_s, empty_s, pop_s, push_s;

    assign full_s  = (count_q == DEPTH_CNT);
    assign empty_s = (count_q == CNTW'(0));

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so a full FIFO still accepts a push then
    always_comb begin
        pop_s      = (state_q == IDLE) && !empty_s;
        push_s     = bus.wordValid && (!full_s || pop_s);
        wr_ptr_d   = push_s ? (wr_ptr_q + PTRWIDTH'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + PTRWIDTH'(1)) : rd_ptr_q;
        overflow_d = overflow_q | (bus.wordValid && full_s && !pop_s);
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Serializer: the word is padded to whole bytes and shifted right one byte per accepted handshake
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    state_d               = SEND;
                    shift_d               = {SHW{1'b0}};
                    shift_d[WIDTH-1:0]    = mem_q[rd_ptr_q];
                    idx_d                 = {IDXW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (bus.byteReady) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        shift_d = {SHW{1'b0}};
                        idx_d   = {IDXW{1'b0}};
                    end else begin
                        shift_d = shift_q >> 4'd8;
                        idx_d   = idx_q + IDXW'(1);
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = {SHW{1'b0}};
                idx_d   = {IDXW{1'b0}};
            end
        endcase
    end

    // Control and serializer state, cleared by the synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= {PTRWIDTH{1'b0}};
            rd_ptr_q   <= {PTRWIDTH{1'b0}};
            count_q    <= {CNTW{1'b0}};
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= {SHW{1'b0}};
            idx_q      <= {IDXW{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
        end
    end

    // Storage array; contents need no reset because the pointers define what is valid
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.wordIn;
        end
    end

    assign bus.byteValid = (state_q == SEND);
    assign bus.byteOut   = shift_q[7:0];
    assign bus.lastByte  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign bus.full      = full_s;
    assign bus.empty     = empty_s;
    assign bus.overflow  = overflow_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_io_output_buffer.sv
// Bench for io_output_buffer (DEPTH=4): directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the buffer.
module tb_io_output_buffer;
    localparam int WIDTH = 36;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;
    localparam int BYTES = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    io_output_buffer_if #(.WIDTH(WIDTH), .PTRWIDTH(PTRW)) bus ();
    io_output_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRWIDTH(PTRW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // model state
    logic [WIDTH-1:0] m_fifo [$];
    logic [WIDTH-1:0] m_cur;
    int               m_idx;
    bit               m_sending;
    bit               m_ovf;
    bit               started;
    bit               m_was_full;
    bit               m_pop;
    logic [7:0]       m_rx [$];
    logic [7:0]       dut_rx [$];
    logic [7:0]       exp_q [$];
    logic             s_valid;
    logic [7:0]       s_byte;
    int               vectors = 0;
    int               errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_word(input logic [WIDTH-1:0] w);
        for (int b = 0; b < BYTES; b++) exp_q.push_back(8'(w >> (8 * b)));
    endtask

    task automatic expect_rx(input string name);
        check({name, "_len"}, 64'(dut_rx.size()), 64'(exp_q.size()));
        check({name, "_model_len"}, 64'(m_rx.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < dut_rx.size()) check(name, 64'(dut_rx[i]), 64'(exp_q[i]));
            if (i < m_rx.size())   check({name, "_model"}, 64'(m_rx[i]), 64'(exp_q[i]));
        end
        dut_rx.delete();
        m_rx.delete();
        exp_q.delete();
    endtask

    // Model update on each edge, then compare all outputs 1 time unit later
    always begin
        @(posedge clock);
        if (!reset && s_valid === 1'b1 && bus.byteReady) dut_rx.push_back(s_byte);
        if (reset) begin
            m_fifo.delete();
            m_sending = 1'b0;
            m_idx     = 0;
            m_cur     = '0;
            m_ovf     = 1'b0;
            started   = 1'b1;
        end else begin
            m_was_full = (m_fifo.size() == DEPTH);
            m_pop      = !m_sending && (m_fifo.size() != 0);
            if (m_sending && bus.byteReady) begin
                m_rx.push_back(8'(m_cur >> (8 * m_idx)));
                if (m_idx == BYTES - 1) m_sending = 1'b0;
                else m_idx++;
            end
            if (m_pop) begin
                m_cur     = m_fifo.pop_front();
                m_sending = 1'b1;
                m_idx     = 0;
            end
            if (bus.wordValid) begin
                if (!m_was_full || m_pop) m_fifo.push_back(bus.wordIn);
                else m_ovf = 1'b1;
            end
        end
        #1;
        s_valid = bus.byteValid;
        s_byte  = bus.byteOut;
        if (started) begin
            check("byteValid", 64'(bus.byteValid), 64'(m_sending));
            check("byteOut",   64'(bus.byteOut), m_sending ? 64'(8'(m_cur >> (8 * m_idx))) : 64'd0);
            check("lastByte",  64'(bus.lastByte), 64'(m_sending && (m_idx == BYTES - 1)));
            check("count",     64'(bus.count), 64'(m_fifo.size()));
            check("full",      64'(bus.full), 64'(m_fifo.size() == DEPTH));
            check("empty",     64'(bus.empty), 64'(m_fifo.size() == 0));
            check("overflow",  64'(bus.overflow), 64'(m_ovf));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        bit   found;
        logic [63:0] r;
        bus.wordValid = 1'b0;
        bus.wordIn    = '0;
        bus.byteReady = 1'b0;
        step(2);
        reset = 1'b0;
        check("rst_byteValid", 64'(bus.byteValid), 64'd0);
        check("rst_byteOut",   64'(bus.byteOut), 64'd0);
        check("rst_count",     64'(bus.count), 64'd0);
        check("rst_empty",     64'(bus.empty), 64'd1);
        check("rst_full",      64'(bus.full), 64'd0);

        // single word, sink always ready
        bus.byteReady = 1'b1;
        bus.wordValid = 1'b1;
        bus.wordIn    = 36'h9_8765_4321;
        step(1);
        bus.wordValid = 1'b0;
        check("t1_count_after_push", 64'(bus.count), 64'd1);
        step(1);
        check("t1_byte0_visible", 64'(bus.byteValid), 64'd1);
        check("t1_byte0_value",   64'(bus.byteOut), 64'h21);
        step(8);
        exp_q = {8'h21, 8'h43, 8'h65, 8'h87, 8'h09};
        expect_rx("t1_bytes");

        // backpressure pattern 1,0,0 repeating
        bus.wordValid = 1'b1;
        bus.wordIn    = 36'h9_8765_4321;
        for (int i = 0; i < 30; i++) begin
            bus.byteReady = (i % 3 == 0);
            step(1);
            bus.wordValid = 1'b0;
        end
        bus.byteReady = 1'b0;
        step(2);
        exp_q = {8'h21, 8'h43, 8'h65, 8'h87, 8'h09};
        expect_rx("t2_bytes");

        // overflow: sink stalled, six words into a four-deep FIFO
        for (int k = 1; k <= 6; k++) begin
            bus.wordValid = 1'b1;
            bus.wordIn    = 36'(k);
            step(1);
        end
        bus.wordValid = 1'b0;
        step(1);
        check("t3_count",    64'(bus.count), 64'd4);
        check("t3_full",     64'(bus.full), 64'd1);
        check("t3_overflow", 64'(bus.overflow), 64'd1);
        bus.byteReady = 1'b1;
        step(40);
        check("t3_overflow_sticky", 64'(bus.overflow), 64'd1);
        for (int k = 1; k <= 5; k++) add_word(36'(k));
        expect_rx("t3_drain");

        // push while full in the same cycle as the pop
        pulse_reset();
        bus.byteReady = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.wordValid = 1'b1;
            bus.wordIn    = 36'h1_0000_0000 + 36'(k);
            step(1);
        end
        bus.wordValid = 1'b0;
        bus.byteReady = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!m_sending && m_fifo.size() == DEPTH) found = 1'b1;
            else step(1);
        end
        check("t4_reached_full_idle", 64'(found), 64'd1);
        bus.wordValid = 1'b1;
        bus.wordIn    = 36'h1_0000_0006;
        step(1);
        bus.wordValid = 1'b0;
        check("t4_count",    64'(bus.count), 64'd4);
        check("t4_overflow", 64'(bus.overflow), 64'd0);
        step(40);
        for (int k = 1; k <= 6; k++) add_word(36'h1_0000_0000 + 36'(k));
        expect_rx("t4_order");

        // reset with byte 2 pending and three words queued
        pulse_reset();
        bus.byteReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.wordValid = 1'b1;
            bus.wordIn    = 36'hA_0000_0000 + 36'(k);
            step(1);
        end
        bus.wordValid = 1'b0;
        bus.byteReady = 1'b1;
        step(2);
        bus.byteReady = 1'b0;
        check("t5_model_idx", 64'(m_idx), 64'd2);
        check("t5_pre_count", 64'(bus.count), 64'd3);
        pulse_reset();
        check("t5_byteValid", 64'(bus.byteValid), 64'd0);
        check("t5_count",     64'(bus.count), 64'd0);
        check("t5_empty",     64'(bus.empty), 64'd1);
        check("t5_overflow",  64'(bus.overflow), 64'd0);
        dut_rx.delete();
        m_rx.delete();
        bus.byteReady = 1'b1;
        bus.wordValid = 1'b1;
        bus.wordIn    = 36'h1_2345_6789;
        step(1);
        bus.wordValid = 1'b0;
        step(10);
        exp_q = {8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        expect_rx("t5_fresh");

        // back-to-back words
        bus.wordValid = 1'b1;
        bus.wordIn    = 36'h0_0000_00FF;
        step(1);
        bus.wordIn    = 36'hF_FFFF_FFFF;
        step(1);
        bus.wordValid = 1'b0;
        step(16);
        exp_q = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        expect_rx("t6_bytes");

        // random traffic with occasional resets and varying sink readiness
        for (int i = 0; i < 3000; i++) begin
            r             = {$urandom, $urandom};
            reset         = ($urandom_range(0, 299) == 0);
            bus.wordValid = ($urandom_range(0, 2) == 0);
            bus.wordIn    = r[35:0];
            bus.byteReady = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 3) == 0);
            step(1);
        end
        reset         = 1'b0;
        bus.wordValid = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
